uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter that serialises one word per valid/ready handshake onto the RsTx line, LSB first. Frame format is configurable: data width, stop-bit count, optional parity, and bit period in clocks. It sits between the board-level command/data logic and the Basys3 USB-UART pin. Unlike the earlier trigger-edge transmitter, it provides back-pressure, a baud-rate divider, a reset and a busy indication.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200); legal ≥ 2.
- DATA_BITS, 8: payload width; legal 5–9.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk, in, 1: system clock. One clock domain only.
- rst_n, in, 1: reset. Asynchronous assert, active-low.
- data, in, DATA_BITS: payload. Sampled on accept.
- valid, in, 1: data is presented.
- ready, out, 1: the block can accept. A transfer occurs when valid && ready at a rising clk edge.
- busy, out, 1: a frame is in progress.
- RsTx, out, 1: serial line. Idle is high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: state = IDLE, RsTx = 1, ready = 1, busy = 0. Bit-period counter and bit index are 0. The shift register is cleared.
- IDLE:
  - ready = 1, RsTx = 1.
  - On accept: latch data into the shift register, compute parity, clear counters, go to START.
- START: RsTx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - RsTx = shift[0] for each bit period, then shift right.
  - After DATA_BITS periods, go to PARITY if enabled, else go to STOP.
- PARITY: RsTx = parity bit for one bit period.
  - Even: XOR of the payload.
  - Odd: its inverse.
- STOP:
  - RsTx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE.
- The bit-period counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT−1 and wraps to 0 at the end of each bit. The end-of-bit tick occurs at count CLKS_PER_BIT−1.
- busy = (state != IDLE). ready = (state == IDLE). Both are registered.
- data and valid are ignored outside IDLE. There is no buffering; the source must hold the word until accepted.
- Reset mid-frame: RsTx goes high immediately (asynchronously). The frame is abandoned and no partial frame resumes after reset release.

## Timing
- Accept at edge N: RsTx = 0, busy = 1 and ready = 0 are all visible after edge N (registered outputs).
- The start bit spans edges N..N+CLKS_PER_BIT.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P is 1 with parity and 0 without.
- ready returns to 1 on the edge that ends the last stop bit.
- If valid is held high, the next start bit begins one cycle later. There is exactly one extra idle-high clock between back-to-back frames.
- valid asserted during reset, or in the first cycle after reset release: accepted on the first edge with rst_n = 1.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state and parity logic are compiled in, and PARITY_MODE selects none, odd or even.
  - Undefined: the PARITY state is absent, PARITY_MODE is ignored, and frames are always parity-free.

## Structure
- Package uart_pkg holds:
  - the state enum type uart_tx_state_t;
  - parity constants UART_PAR_NONE = 0, UART_PAR_ODD = 1, UART_PAR_EVEN = 2.
  - Any future receiver shares this package.
- One sub-module, uart_baud_tick: the bit-period counter with inputs clk, rst_n, clear and output tick. It is reused later by the receiver.
- The FSM, shift register and parity logic stay in the top level.

## Test plan
Directed tests use CLKS_PER_BIT = 4 unless stated.
- Reset then idle: after release, RsTx = 1, ready = 1 and busy = 0 for 20 cycles.
- 8N1, data = 0x55: RsTx reads 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles. ready returns after 40 cycles.
- Back-pressure: valid held high with data 0xA3, then 0x3C. Exactly two frames are sent with one idle clock between them. A data change while busy does not corrupt the frame in flight.
- UART_TX_PARITY_EN defined, PARITY_MODE = 2, DATA_BITS = 7, data = 0x07: parity bit = 1 and the frame is 40 cycles. With PARITY_MODE = 1 the parity bit is 0.
- STOP_BITS = 2, data = 0xFF: the line stays high for 8 cycles after the last data bit before ready rises.
- rst_n pulsed low mid-DATA:
  - RsTx = 1 immediately, with no clock edge needed.
  - After release, ready = 1.
  - The next accepted 0x12 produces a clean, complete frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and any later receiver.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_ODD  = 1;
  localparam int UART_PAR_EVEN = 2;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake between a data source and the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick on the last count of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready accept, LSB first, registered line output.
// Optional parity bit compiled in with UART_TX_PARITY_EN.
//   state  | meaning
//   IDLE   | line high, ready for a word
//   START  | start bit (low)
//   DATA   | payload bits, LSB first
//   PARITY | parity bit (only with UART_TX_PARITY_EN)
//   STOP   | STOP_BITS high bit periods
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_MODE  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_frame_if.slave  s,
  output logic            busy,
  output logic            RsTx
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
      STOP_BITS > 2 || PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter combination");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 rstx_q, rstx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 tick;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = (PARITY_MODE != UART_PAR_NONE);
  logic par_q, par_d;
`endif

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (s.valid) begin
          shift_d    = s.data;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d      = (PARITY_MODE == UART_PAR_ODD) ? ~(^s.data) : ^s.data;
`endif
          state_d    = START;
        end
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PAR_EN ? PARITY : STOP;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: begin
        if (tick) begin
          if (stop_idx_q == LAST_STOP) begin
            stop_idx_d = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered, so derive it from where the FSM is going.
    case (state_d)
      START:   rstx_d = 1'b0;
      DATA:    rstx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  rstx_d = par_d;
`endif
      default: rstx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      rstx_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      rstx_q     <= rstx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign s.ready = ready_q;
  assign busy    = busy_q;
  assign RsTx    = rstx_q;
endmodule
